// File: rtl/soc_io_pkg.sv
// Shared definitions for the SOC I/O page: register decode bits, status bit
// positions and the UART transmitter state encoding.
package soc_io_pkg;

   // One-hot word-offset address bits selecting each I/O register
   localparam int REG_LED_BIT  = 2;
   localparam int REG_DATA_BIT = 3;
   localparam int REG_STAT_BIT = 4;

   // Bit positions inside the UART status word
   localparam int STAT_FULL_BIT = 8;
   localparam int STAT_BUSY_BIT = 9;
   localparam int STAT_OVR_BIT  = 10;

   // Data bits per UART character (8N1)
   localparam int UART_BITS = 8;

   // Transmitter frame phases
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a one-byte holding buffer in front of the shift
// register. A write that finds the buffer occupied is dropped and reported via
// a single-cycle overrun pulse; a write coinciding with the FSM popping the
// buffer is accepted. The serial line is driven from a register so it never
// glitches, and it is aligned with the FSM phase (it carries the value of the
// phase the FSM is in).
module uart_tx_buffered
   import soc_io_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 25000000,
   parameter int BAUD        = 115200
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       wr,
   input  logic [7:0] wdata,
   output logic       tx,
   output logic       full,
   output logic       busy,
   output logic       overrun_pulse
);

   // Clock cycles per bit; truncating division, expected to be at least 2
   localparam int DIV   = CLK_FREQ_HZ / BAUD;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [2:0]       BIT_LAST = 3'(UART_BITS - 1);

   tx_state_t        state;
   tx_state_t        state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_nx;
   logic [7:0]       shift;
   logic [7:0]       shift_nx;
   logic [7:0]       hold;
   logic             tick;
   logic             pop;
   logic             accept;
   logic             tx_nx;

   // Last cycle of the current bit period
   assign tick = (cnt == CNT_LAST);

   // The idle FSM takes the buffered byte as soon as it sees one
   assign pop = (state == TX_IDLE) && full;

   // A write lands if the buffer is empty or is being emptied this very cycle
   assign accept        = wr && (!full || pop);
   assign overrun_pulse = wr && full && !pop;

   assign busy = full || (state != TX_IDLE);

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= TX_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next-state: walk start, eight data bits, stop, one bit period each
   always_comb begin
      state_nx = state;
      case (state)
         TX_IDLE:  if (full) state_nx = TX_START;
         TX_START: if (tick) state_nx = TX_DATA;
         TX_DATA:  if (tick && (bit_idx == BIT_LAST)) state_nx = TX_STOP;
         TX_STOP:  if (tick) state_nx = TX_IDLE;
         default:  state_nx = TX_IDLE;
      endcase
   end

   // Next values of the baud counter, bit index and shift register
   always_comb begin
      cnt_nx     = '0;
      bit_idx_nx = bit_idx;
      shift_nx   = shift;
      if ((state != TX_IDLE) && !tick) begin
         cnt_nx = cnt + CNT_W'(1);
      end
      if (state == TX_START) begin
         bit_idx_nx = '0;
      end
      if (pop) begin
         shift_nx = hold;
      end else if ((state == TX_DATA) && tick) begin
         shift_nx   = {1'b0, shift[7:1]};
         bit_idx_nx = bit_idx + 3'd1;
      end
   end

   // FSM output: line level for the phase being entered, LSB first
   always_comb begin
      tx_nx = 1'b1;
      case (state_nx)
         TX_START: tx_nx = 1'b0;
         TX_DATA:  tx_nx = shift_nx[0];
         default:  tx_nx = 1'b1;
      endcase
   end

   // Control registers: bit timing and the registered serial line
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
      end else begin
         cnt     <= cnt_nx;
         bit_idx <= bit_idx_nx;
         tx      <= tx_nx;
      end
   end

   // Buffer occupancy: load on an accepted write, clear when popped alone
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         full <= 1'b0;
      end else if (accept) begin
         full <= 1'b1;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

   // Data registers: contents only matter once qualified by full or the FSM
   always_ff @(posedge clk) begin
      shift <= shift_nx;
      if (accept) begin
         hold <= wdata;
      end
   end

endmodule

// File: rtl/soc_io_page.sv
// Memory-mapped I/O page beside the RAM on the processor bus. Any access with
// the page bit set is claimed here. Registers are selected one-hot by word
// offset bits: LED, UART data and UART status. Several bits set on a write
// writes every selected register; on a read the lowest set bit wins.
module soc_io_page
   import soc_io_pkg::*;
#(
   parameter int IO_BIT      = 22,
   parameter int LED_W       = 8,
   parameter int CLK_FREQ_HZ = 25000000,
   parameter int BAUD        = 115200
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic [3:0]       mem_wmask,
   input  logic             mem_rstrb,
   output logic [31:0]      io_rdata,
   output logic [LED_W-1:0] led,
   output logic             uart_tx
);

   logic        sel;
   logic        wr;
   logic        rd;
   logic        led_wr;
   logic        data_wr;
   logic        stat_rd;
   logic [31:0] led_ext;
   logic [31:0] stat_word;
   logic [31:0] rd_val;
   logic        uart_full;
   logic        uart_busy;
   logic        ovr_pulse;
   logic        overrun;
   logic        unused_ok;

   assign sel = mem_addr[IO_BIT];
   assign wr  = sel && (mem_wmask != 4'b0000);
   assign rd  = sel && mem_rstrb;

   // Registers hold byte data, so only the low byte lane qualifies a write
   assign led_wr  = wr && mem_wmask[0] && mem_addr[REG_LED_BIT];
   assign data_wr = wr && mem_wmask[0] && mem_addr[REG_DATA_BIT];

   // Only a read that actually resolves to the status register clears overrun
   assign stat_rd = rd && !mem_addr[REG_LED_BIT] && !mem_addr[REG_DATA_BIT]
                    && mem_addr[REG_STAT_BIT];

   // Address and data bits outside the decode carry no meaning for this page
   assign unused_ok = ^{mem_addr, mem_wdata};

   uart_tx_buffered #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD        (BAUD)
   ) u_uart (
      .clk           (clk),
      .resetn        (resetn),
      .wr            (data_wr),
      .wdata         (mem_wdata[7:0]),
      .tx            (uart_tx),
      .full          (uart_full),
      .busy          (uart_busy),
      .overrun_pulse (ovr_pulse)
   );

   // Zero-extended LED value and assembled status word
   always_comb begin
      led_ext = '0;
      led_ext[LED_W-1:0] = led;
      stat_word = '0;
      stat_word[STAT_OVR_BIT]  = overrun;
      stat_word[STAT_BUSY_BIT] = uart_busy;
      stat_word[STAT_FULL_BIT] = uart_full;
   end

   // Read mux with lowest-offset priority; unmapped offsets read as zero
   always_comb begin
      rd_val = '0;
      if (mem_addr[REG_LED_BIT]) begin
         rd_val = led_ext;
      end else if (mem_addr[REG_DATA_BIT]) begin
         rd_val = '0;
      end else if (mem_addr[REG_STAT_BIT]) begin
         rd_val = stat_word;
      end
   end

   // Registered read data, one cycle after the strobe like the RAM
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         io_rdata <= '0;
      end else if (rd) begin
         io_rdata <= rd_val;
      end
   end

   // LED register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led <= '0;
      end else if (led_wr) begin
         led <= mem_wdata[LED_W-1:0];
      end
   end

   // Sticky overrun: a new drop outranks the clearing status read
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overrun <= 1'b0;
      end else if (ovr_pulse) begin
         overrun <= 1'b1;
      end else if (stat_rd) begin
         overrun <= 1'b0;
      end
   end

endmodule
